// File: rtl/moving_average_sample_source.sv
// -----------------------------------------------------------------------------
// moving_average_sample_source
//
// Transmit end of the strobed-sample interface in front of the moving averager.
// Host-written samples are buffered in a small FIFO and issued as
// sample_out/strobe_out pairs. After each strobe the block waits a programmable
// number of idle cycles before it issues the next one.
//
// Parameters:
//   ADDR_W     FIFO address width; depth = 2**ADDR_W
//   DATA_W     sample width
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_data    sample to enqueue
//   wr_en      enqueue request, one sample per cycle
//   full       FIFO holds 2**ADDR_W entries (decoded from level)
//   level      current FIFO occupancy
//   enable     1 = pop/transmit allowed, 0 = pause
//   interval   idle cycles required after each strobe, sampled at pop
//   flush      synchronous FIFO and gap-counter clear
//   ovf_clr    clears the sticky overflow flag
//   sample_out transmitted sample
//   strobe_out one-cycle valid pulse
//   overflow   sticky: a write was dropped while full
//
// Build option:
//   IDLE_ZERO_EN  when defined, sample_out reads 0 in every cycle where
//                 strobe_out=0. When undefined, sample_out holds the last
//                 transmitted sample.
//
// The control states PAUSED / GAP / READY are implicit in enable and gap_cnt.
// No separate state register is kept.
// -----------------------------------------------------------------------------
module moving_average_sample_source #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic [ADDR_W:0]   level,
    input  logic              enable,
    input  logic [7:0]        interval,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] sample_out,
    output logic              strobe_out,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        gap_cnt;

    logic pop;
    logic wr_accept;
    logic wr_drop;

    // Occupancy is the only source for full/empty, so equal pointers are never
    // ambiguous.
    assign full = (level == LEVEL_FULL);

    // A pop uses the registered level. A sample written this cycle can
    // therefore leave the block no earlier than the next cycle.
    assign pop = enable && (level != '0) && (gap_cnt == '0) && !flush;

    // When the FIFO is full, a write is still accepted if a pop frees a slot
    // in the same cycle. Flush discards the write and never counts as a drop.
    assign wr_accept = wr_en && !flush && (!full || pop);
    assign wr_drop   = wr_en && !flush && full && !pop;

    // NOTE: the storage array has no reset. Its contents are only ever read
    // behind level != 0, so clearing it would cost flops and buy nothing.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments. Every update then
    // sees the values from before the edge. In particular, a full-FIFO
    // write-with-pop reads the old head at rd_ptr before the new sample lands
    // in the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            gap_cnt    <= '0;
            sample_out <= '0;
            strobe_out <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            gap_cnt    <= '0;
            strobe_out <= 1'b0;
`ifdef IDLE_ZERO_EN
            sample_out <= '0;
`endif
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({wr_accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (pop) begin
                sample_out <= mem[rd_ptr];
                strobe_out <= 1'b1;
                rd_ptr     <= rd_ptr + 1'b1;
                // Loading interval at pop makes the spacing interval+1 cycles.
                gap_cnt    <= interval;
            end else begin
                strobe_out <= 1'b0;
`ifdef IDLE_ZERO_EN
                sample_out <= '0;
`endif
                // The gap keeps draining while paused, so re-enabling never
                // shortens it.
                if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end

    // Sticky overflow. A drop in the same cycle as ovf_clr wins. Flush leaves
    // the flag alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_average_sample_source.sv
// -----------------------------------------------------------------------------
// tb_moving_average_sample_source
//
// Directed bench for moving_average_sample_source. Inputs change 1 ns after a
// rising edge. A negedge monitor logs every strobe (sample and edge index).
// Expected values below are written out by hand from the block's behaviour.
// Defining IDLE_ZERO_EN switches the sample_out expectations used between
// strobes.
// -----------------------------------------------------------------------------
module tb_moving_average_sample_source;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic [2:0] level;
    logic       enable;
    logic [7:0] interval;
    logic       flush;
    logic       ovf_clr;
    logic [7:0] sample_out;
    logic       strobe_out;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wcyc;
    int gcyc;

    logic [7:0] sq[$];
    int         cq[$];

    logic [7:0] exp_t1 [4] = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    logic [7:0] exp_t2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp_t4 [5] = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h66};

    moving_average_sample_source #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .level      (level),
        .enable     (enable),
        .interval   (interval),
        .flush      (flush),
        .ovf_clr    (ovf_clr),
        .sample_out (sample_out),
        .strobe_out (strobe_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && strobe_out) begin
            sq.push_back(sample_out);
            cq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic clear_log();
        sq.delete();
        cq.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_data  = '0;
        wr_en    = 1'b0;
        enable   = 1'b0;
        interval = '0;
        flush    = 1'b0;
        ovf_clr  = 1'b0;

        // ---- reset state
        idle(3);
        check("rst_level",    level, 0);
        check("rst_full",     full, 0);
        check("rst_strobe",   strobe_out, 0);
        check("rst_sample",   sample_out, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        idle(2);

        // ---- T1: interval=1, four writes, strobes every 2 cycles
        interval = 8'd1;
        enable   = 1'b1;
        clear_log();
        write(8'hAA);
        wcyc = cyc;
        write(8'h55);
        write(8'hFF);
        write(8'h00);
        idle(8);
        check("t1_count", sq.size(), 4);
        if (sq.size() == 4) begin
            check("t1_first_lat", cq[0], wcyc + 1);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t1_sample%0d", i), sq[i], exp_t1[i]);
                if (i > 0) check($sformatf("t1_space%0d", i), cq[i] - cq[i-1], 2);
            end
        end
        check("t1_level", level, 0);

        // ---- T2: preload 4 while paused, interval=0, back-to-back strobes
        enable   = 1'b0;
        interval = 8'd0;
        clear_log();
        for (int i = 0; i < 4; i++) write(exp_t2[i]);
        check("t2_full",    full, 1);
        check("t2_level",   level, 4);
        check("t2_nopop",   sq.size(), 0);
        enable = 1'b1;
        tick();
        gcyc = cyc;
        idle(6);
        check("t2_count", sq.size(), 4);
        if (sq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t2_sample%0d", i), sq[i], exp_t2[i]);
                check($sformatf("t2_cyc%0d", i), cq[i], gcyc + i);
            end
        end
        check("t2_level_end", level, 0);
`ifdef IDLE_ZERO_EN
        check("t2_idle_sample", sample_out, 8'h00);
`else
        check("t2_hold_sample", sample_out, 8'h44);
`endif

        // ---- T3: overflow on 5th write, sticky until ovf_clr
        enable = 1'b0;
        clear_log();
        for (int i = 1; i <= 4; i++) write(8'(i));
        check("t3_full",    full, 1);
        check("t3_ovf_pre", overflow, 0);
        write(8'h05);
        check("t3_ovf",      overflow, 1);
        check("t3_level",    level, 4);
        enable = 1'b1;
        idle(7);
        check("t3_count", sq.size(), 4);
        if (sq.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_sample%0d", i), sq[i], 8'(i + 1));
        end
        check("t3_ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // ---- T4: write while full in the same cycle as a pop
        enable = 1'b0;
        for (int i = 0; i < 4; i++) write(exp_t4[i]);
        check("t4_full", full, 1);
        clear_log();
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h66;
        tick();
        wr_en = 1'b0;
        check("t4_level",  level, 4);
        check("t4_ovf",    overflow, 0);
        check("t4_strobe", strobe_out, 1);
        check("t4_head",   sample_out, 8'h71);
        idle(6);
        check("t4_count", sq.size(), 5);
        if (sq.size() == 5) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("t4_sample%0d", i), sq[i], exp_t4[i]);
        end

        // ---- T5: async reset mid-gap with samples queued
        enable   = 1'b0;
        interval = 8'd3;
        write(8'hA1);
        write(8'hA2);
        write(8'hA3);
        enable = 1'b1;
        tick();
        check("t5_strobe",  strobe_out, 1);
        check("t5_sample",  sample_out, 8'hA1);
        check("t5_level",   level, 2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_strobe", strobe_out, 0);
        check("t5_rst_sample", sample_out, 0);
        check("t5_rst_level",  level, 0);
        tick();
        rst_n = 1'b1;
        clear_log();
        idle(12);
        check("t5_no_strobe", sq.size(), 0);
        check("t5_level_end", level, 0);

        // ---- T6: flush one cycle after first strobe, with simultaneous write
        enable   = 1'b0;
        interval = 8'd5;
        write(8'hB1);
        write(8'hB2);
        write(8'hB3);
        clear_log();
        enable = 1'b1;
        tick();
        check("t6_strobe", strobe_out, 1);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hC1;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        check("t6_level",  level, 0);
        check("t6_strobe_off", strobe_out, 0);
        check("t6_ovf",    overflow, 0);
`ifdef IDLE_ZERO_EN
        check("t6_sample", sample_out, 8'h00);
`else
        check("t6_sample", sample_out, 8'hB1);
`endif
        idle(12);
        check("t6_count",     sq.size(), 1);
        check("t6_level_end", level, 0);
`ifdef IDLE_ZERO_EN
        check("t6_sample_end", sample_out, 8'h00);
`else
        check("t6_sample_end", sample_out, 8'hB1);
`endif

        // ---- T7: drop beats ovf_clr; flush leaves overflow set
        enable = 1'b0;
        for (int i = 0; i < 4; i++) write(8'hD0 + 8'(i));
        ovf_clr = 1'b1;
        write(8'hD6);
        ovf_clr = 1'b0;
        check("t7_ovf_set_wins", overflow, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t7_level", level, 0);
        check("t7_full",  full, 0);
        check("t7_ovf_kept", overflow, 1);
        clear_log();
        enable = 1'b1;
        idle(4);
        check("t7_no_strobe", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
